// File: rtl/peripheral_adder_pipe.sv
// peripheral_adder_pipe: two-stage valid/ready adder with a
// completed-transfer counter and a sticky carry-out flag.
module peripheral_adder_pipe #(
   parameter int DW    = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DW-1:0]    x,
   input  logic [DW-1:0]    y,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [DW-1:0]    sum,
   output logic             cout,
   input  logic             clear,
   output logic [CNT_W-1:0] txn_count,
   output logic             carry_seen
);

   typedef struct packed {
      logic          v;
      logic [DW-1:0] x;
      logic [DW-1:0] y;
      logic          c;
   } s1_t;

   typedef struct packed {
      logic          v;
      logic [DW-1:0] s;
      logic          c;
   } s2_t;

   s1_t              s1_q;
   s2_t              s2_q;
   logic             s2_adv;
   logic             out_fire;
   logic [DW:0]      add_res;
   logic [CNT_W-1:0] cnt_q;
   logic             seen_q;

   assign s2_adv   = !s2_q.v | out_ready;
   assign in_ready = !s1_q.v | s2_adv;
   assign out_fire = s2_q.v & out_ready;

   assign add_res = {1'b0, s1_q.x}
                  + {1'b0, s1_q.y}
                  + {{DW{1'b0}}, s1_q.c};

   // S1 only refills when it is empty or draining into S2.
   always_ff @(posedge clk) begin
      if (!reset) begin
         s1_q <= '0;
      end else if (in_ready) begin
         s1_q.v <= in_valid;
         if (in_valid) begin
            s1_q.x <= x;
            s1_q.y <= y;
            s1_q.c <= cin;
         end
      end
   end

   // Data is only written on a real load so a stalled or
   // emptied result register keeps its last value.
   always_ff @(posedge clk) begin
      if (!reset) begin
         s2_q <= '0;
      end else if (s2_adv) begin
         s2_q.v <= s1_q.v;
         if (s1_q.v) begin
            s2_q.s <= add_res[DW-1:0];
            s2_q.c <= add_res[DW];
         end
      end
   end

   // clear outranks a transfer on the same edge.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q  <= '0;
         seen_q <= 1'b0;
      end else if (clear) begin
         cnt_q  <= '0;
         seen_q <= 1'b0;
      end else if (out_fire) begin
         cnt_q <= cnt_q + 1'b1;
         if (s2_q.c) begin
            seen_q <= 1'b1;
         end
      end
   end

   assign out_valid  = s2_q.v;
   assign sum        = s2_q.s;
   assign cout       = s2_q.c;
   assign txn_count  = cnt_q;
   assign carry_seen = seen_q;

endmodule
